// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared op encodings and helpers for the restoring divider
package div_unit_pkg;

  localparam int DIV_OP_WIDTH = 2;

  typedef enum logic [DIV_OP_WIDTH-1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_restore_step.sv
// rtl/div_unit_restore_step.sv - one combinational radix-2 restoring division step
module div_unit_restore_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_trial;
  logic          w_fits;

  // One extra bit so the shifted remainder and the trial sign never overflow.
  assign w_rem_sh = {i_rem, i_quo[XLEN-1]};
  assign w_trial  = w_rem_sh - {1'b0, i_divisor};
  assign w_fits   = ~w_trial[XLEN];

  assign o_rem = w_fits ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign o_quo = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit with one-cycle ready pulse
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  div_state_e      r_state;
  div_state_e      w_state_nxt;
  div_op_e         r_op;
  logic            r_dvd_neg;
  logic            r_dvs_neg;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_result;

  logic            w_signed;
  logic            w_dvd_neg;
  logic            w_dvs_neg;
  logic [XLEN-1:0] w_dvd_mag;
  logic [XLEN-1:0] w_dvs_mag;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_step_rem;
  logic [XLEN-1:0] w_step_quo;
  logic [XLEN-1:0] w_final;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  assign w_signed   = op_is_signed(div_op_e'(op));
  assign w_dvd_neg  = w_signed & dividend[XLEN-1];
  assign w_dvs_neg  = w_signed & divisor[XLEN-1];
  assign w_dvd_mag  = w_dvd_neg ? (~dividend + 1'b1) : dividend;
  assign w_dvs_mag  = w_dvs_neg ? (~divisor + 1'b1) : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = w_signed & (dividend == MIN_NEG) & (divisor == '1);
  assign w_special  = w_div_zero | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = op_is_rem(div_op_e'(op)) ? dividend : '1;
    end else if (!op_is_rem(div_op_e'(op))) begin
      w_special_res = MIN_NEG;
    end
  end

  div_unit_restore_step #(.XLEN(XLEN)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  always_comb begin
    w_final = w_step_quo;
    case (r_op)
      DIV_OP_DIV:  w_final = (r_dvd_neg ^ r_dvs_neg) ? (~w_step_quo + 1'b1) : w_step_quo;
      DIV_OP_DIVU: w_final = w_step_quo;
      DIV_OP_REM:  w_final = r_dvd_neg ? (~w_step_rem + 1'b1) : w_step_rem;
      DIV_OP_REMU: w_final = w_step_rem;
      default:     w_final = w_step_quo;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (valid) w_state_nxt = w_special ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == '0) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op      <= DIV_OP_DIV;
      r_dvd_neg <= 1'b0;
      r_dvs_neg <= 1'b0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid) begin
            r_op      <= div_op_e'(op);
            r_dvd_neg <= w_dvd_neg;
            r_dvs_neg <= w_dvs_neg;
            r_divisor <= w_dvs_mag;
            r_rem     <= '0;
            r_quo     <= w_dvd_mag;
            r_cnt     <= CW'(XLEN-1);
            if (w_special) r_result <= w_special_res;
          end
        end
        ST_CALC: begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign ready  = (r_state == ST_DONE);
  assign busy   = (r_state != ST_IDLE);
  assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit against an arithmetic model
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        valid;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ready;
  logic [31:0] result;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          t_start  = 0;
  int          exp_lat  = 0;
  int          n_done   = 0;
  logic [31:0] exp_res  = '0;
  logic        active   = 1'b0;
  logic        prev_ready = 1'b0;

  div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .valid    (valid),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .ready    (ready),
    .result   (result),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RV32M semantics straight from the ISA rules, using native signed arithmetic.
  function automatic logic [31:0] model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    int signed sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (mop)
      2'd0:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!mop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  always @(negedge clk) begin
    if (resetn) begin
      check("busy", {31'd0, busy},
            {31'd0, active && (cyc - t_start >= 1) && (cyc - t_start <= exp_lat)});
      if (ready) begin
        if (!active) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          check("result", result, exp_res);
          check("latency", 32'(cyc - t_start), 32'(exp_lat));
          active = 1'b0;
          n_done++;
        end
        if (prev_ready) check("ready_width", 32'd2, 32'd1);
      end
      prev_ready = ready;
    end else begin
      prev_ready = 1'b0;
    end
  end

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit,
                        input int chg_cyc, input logic [31:0] chg_val);
    int done0;
    bit seen;
    check({name, "_model"}, model(o, a, b), lit);
    @(negedge clk); #1;
    done0    = n_done;
    exp_res  = model(o, a, b);
    exp_lat  = model_lat(o, a, b);
    t_start  = cyc;
    active   = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    valid    = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk); #1;
      if (chg_cyc >= 0 && cyc - t_start == chg_cyc) dividend = chg_val;
      if (n_done != done0) seen = 1'b1;
    end
    if (!seen) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      active = 1'b0;
    end
    valid = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    valid    = 1'b0;
    op       = 2'd0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",  {31'd0, ready}, 32'd0);
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_result", result,         32'd0);
    #1 resetn = 1'b1;

    run_op("div_100_7",    2'd0, 32'd100,        32'd7,          32'd14,         -1, '0);
    run_op("rem_100_7",    2'd2, 32'd100,        32'd7,          32'd2,          -1, '0);
    run_op("div_m100_7",   2'd0, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   -1, '0);
    run_op("rem_m100_7",   2'd2, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   -1, '0);
    run_op("rem_m100_m7",  2'd2, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   -1, '0);
    run_op("divu_max_2",   2'd1, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   -1, '0);
    run_op("remu_max_2",   2'd3, 32'hFFFFFFFF,   32'd2,          32'd1,          -1, '0);
    run_op("divu_5_0",     2'd1, 32'd5,          32'd0,          32'hFFFFFFFF,   -1, '0);
    run_op("remu_5_0",     2'd3, 32'd5,          32'd0,          32'd5,          -1, '0);
    run_op("div_m5_0",     2'd0, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   -1, '0);
    run_op("div_ovf",      2'd0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   -1, '0);
    run_op("rem_ovf",      2'd2, 32'h80000000,   32'hFFFFFFFF,   32'd0,          -1, '0);
    run_op("div_min_2",    2'd0, 32'h80000000,   32'd2,          32'hC0000000,   -1, '0);
    run_op("div_7_m2",     2'd0, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   -1, '0);
    run_op("rem_7_m2",     2'd2, 32'd7,          32'hFFFFFFFE,   32'd1,          -1, '0);
    run_op("remu_7_big",   2'd3, 32'd7,          32'h80000000,   32'd7,          -1, '0);
    run_op("div_chg",      2'd0, 32'd100,        32'd7,          32'd14,          5, 32'd9);

    @(negedge clk); #1;
    t_start  = cyc;
    exp_lat  = 33;
    active   = 1'b1;
    op       = 2'd0;
    dividend = 32'd100;
    divisor  = 32'd7;
    valid    = 1'b1;
    while (cyc - t_start < 10) begin
      @(negedge clk); #1;
    end
    #2;
    active = 1'b0;
    valid  = 1'b0;
    resetn = 1'b0;
    #1;
    check("midrst_ready",  {31'd0, ready}, 32'd0);
    check("midrst_busy",   {31'd0, busy},  32'd0);
    check("midrst_result", result,         32'd0);
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(negedge clk);

    run_op("divu_9_3",     2'd1, 32'd9,          32'd3,          32'd3,          -1, '0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
